// File: rtl/mdma_desc_req_fifo_ctl.sv
// Descriptor-request FIFO controller: pushes words into an external RAM and
// prefetches them into a small output buffer so the pop side never sees RAM read latency.
`timescale 1ns/1ps
module mdma_desc_req_fifo_ctl #(
  parameter int DEPTH      = 512,
  parameter int DATA_BITS  = 48,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DATA_BITS-1:0]       in_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_BITS-1:0]       out_dat,
  output logic                       out_dbe,
  output logic                       ram_wen,
  output logic [$clog2(DEPTH)-1:0]   ram_wadr,
  output logic [DATA_BITS-1:0]       ram_wdat,
  output logic                       ram_ren,
  output logic [$clog2(DEPTH)-1:0]   ram_radr,
  input  logic [DATA_BITS-1:0]       ram_rdat,
  input  logic                       ram_rsbe,
  input  logic                       ram_rdbe,
  output logic [$clog2(DEPTH):0]     occ,
  output logic [15:0]                sbe_cnt,
  output logic                       dbe_err
);
  localparam int AW         = $clog2(DEPTH);
  localparam int AW1        = AW + 1;
  localparam int OBUF_DEPTH = RAM_RD_LAT + 1;
  localparam int CW         = $clog2(OBUF_DEPTH + 1);
  localparam int CW1        = CW + 1;
  localparam int IW         = $clog2(OBUF_DEPTH);
  localparam logic [AW:0]   DEPTH_W   = AW1'(DEPTH);
  localparam logic [CW:0]   OBUF_LIM  = CW1'(OBUF_DEPTH);
  localparam logic [CW-1:0] OBUF_FULL = CW'(OBUF_DEPTH);

  logic [AW:0]                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
  logic [AW:0]                         occ_q, occ_d;
  logic [RAM_RD_LAT-1:0]               pipe_vld_q, pipe_vld_d;
  logic [OBUF_DEPTH-1:0][DATA_BITS-1:0] obuf_dat_q, obuf_dat_d;
  logic [OBUF_DEPTH-1:0]               obuf_dbe_q, obuf_dbe_d;
  logic [CW-1:0]                       obuf_cnt_q, obuf_cnt_d, inflight, wpos;
  logic [IW-1:0]                       widx;
  logic [CW:0]                         credit_used;
  logic [15:0]                         sbe_cnt_q, sbe_cnt_d;
  logic                                dbe_err_q, dbe_err_d;
  logic                                push, pop, cap, ren;

  assign ram_cnt = wr_ptr_q - rd_ptr_q;
  assign in_rdy  = (ram_cnt != DEPTH_W);
  assign out_vld = (obuf_cnt_q != '0);
  assign push    = in_vld & in_rdy & ~rst;
  assign pop     = out_vld & out_rdy;
  assign cap     = pipe_vld_q[RAM_RD_LAT-1];

  // A read may issue only if every word already owed to the buffer still fits after this cycle's pop.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_vld_q[i]);
    end
    credit_used = {1'b0, obuf_cnt_q} + {1'b0, inflight} - CW1'(pop);
    ren = ~rst && (ram_cnt != '0) && (credit_used < OBUF_LIM);
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAM_RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_vld_d[gi] = ren;
      end else begin : g_tail
        assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
      end
    end
  endgenerate

  // Output buffer is a shift register: entry 0 is always the head, so outputs hold while stalled.
  always_comb begin
    wpos       = obuf_cnt_q - CW'(pop);
    widx       = wpos[IW-1:0];
    obuf_dat_d = pop ? (obuf_dat_q >> DATA_BITS) : obuf_dat_q;
    obuf_dbe_d = pop ? (obuf_dbe_q >> 1) : obuf_dbe_q;
    if (cap) begin
      obuf_dat_d[widx] = ram_rdat;
      obuf_dbe_d[widx] = ram_rdbe;
    end
    obuf_cnt_d = obuf_cnt_q + CW'(cap) - CW'(pop);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW1'(push);
    rd_ptr_d  = rd_ptr_q + AW1'(ren);
    occ_d     = occ_q + AW1'(push) - AW1'(pop);
    sbe_cnt_d = sbe_cnt_q;
    dbe_err_d = dbe_err_q;
    if (cap) begin
      if (ram_rdbe) begin
        dbe_err_d = 1'b1;
      end else if (ram_rsbe && (sbe_cnt_q != 16'hFFFF)) begin
        sbe_cnt_d = sbe_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pipe_vld_q <= '0;
      obuf_dat_q <= '0;
      obuf_dbe_q <= '0;
      obuf_cnt_q <= '0;
      sbe_cnt_q  <= '0;
      dbe_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pipe_vld_q <= pipe_vld_d;
      obuf_dat_q <= obuf_dat_d;
      obuf_dbe_q <= obuf_dbe_d;
      obuf_cnt_q <= obuf_cnt_d;
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_err_q  <= dbe_err_d;
    end
  end

  obuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(cap && !pop && (obuf_cnt_q == OBUF_FULL)));

  assign out_dat  = obuf_dat_q[0];
  assign out_dbe  = obuf_dbe_q[0];
  assign ram_wen  = push;
  assign ram_wadr = wr_ptr_q[AW-1:0];
  assign ram_wdat = in_dat;
  assign ram_ren  = ren;
  assign ram_radr = rd_ptr_q[AW-1:0];
  assign occ      = occ_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_err  = dbe_err_q;
endmodule

// File: tb/tb_mdma_desc_req_fifo_ctl.sv
// Bench for the descriptor-request FIFO controller: RAM model, queue-based reference and directed phases.
`timescale 1ns/1ps
module tb_mdma_desc_req_fifo_ctl;
  localparam int DEPTH = 512;
  localparam int DB    = 48;
  localparam int AW    = 9;
  localparam int OBUF  = 2;
  localparam logic [DB-1:0] ECC_BASE = 48'hECC0_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, out_rdy = 1'b0;
  logic [DB-1:0] in_dat = '0;
  logic          in_rdy, out_vld, out_dbe, ram_wen, ram_ren, dbe_err;
  logic [DB-1:0] out_dat, ram_wdat;
  logic [DB-1:0] ram_rdat = '0;
  logic          ram_rsbe = 1'b0, ram_rdbe = 1'b0;
  logic [AW-1:0] ram_wadr, ram_radr;
  logic [AW:0]   occ;
  logic [15:0]   sbe_cnt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdma_desc_req_fifo_ctl #(.DEPTH(DEPTH), .DATA_BITS(DB), .RAM_RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_dbe(out_dbe),
    .ram_wen(ram_wen), .ram_wadr(ram_wadr), .ram_wdat(ram_wdat),
    .ram_ren(ram_ren), .ram_radr(ram_radr), .ram_rdat(ram_rdat),
    .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe),
    .occ(occ), .sbe_cnt(sbe_cnt), .dbe_err(dbe_err)
  );

  function automatic logic inj_sbe(input logic [DB-1:0] d);
    return (d == ECC_BASE + 48'd5) || (d == ECC_BASE + 48'd12);
  endfunction
  function automatic logic inj_dbe(input logic [DB-1:0] d);
    return (d == ECC_BASE + 48'd9) || (d == ECC_BASE + 48'd12);
  endfunction

  // One-cycle-latency ECC RAM
  logic [DB-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wadr] <= ram_wdat;
    if (ram_ren) begin
      ram_rdat <= mem[ram_radr];
      ram_rsbe <= inj_sbe(mem[ram_radr]);
      ram_rdbe <= inj_dbe(mem[ram_radr]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: every stored word in order, split into RAM / in-flight / buffer counts
  typedef struct { logic [DB-1:0] d; logic sbe; logic dbe; } wd_t;
  wd_t  q[$];
  wd_t  w;
  int   m_r = 0, m_f = 0, m_b = 0, m_sbe = 0;
  logic m_dbe_err = 1'b0;
  int   u_pop, u_push, u_ren;
  bit   e_rdy, e_vld, e_pop, e_ren;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_r = 0; m_f = 0; m_b = 0; m_sbe = 0; m_dbe_err = 1'b0;
    end else begin
      u_pop  = (m_b > 0 && out_rdy) ? 1 : 0;
      u_push = (in_vld && m_r != DEPTH) ? 1 : 0;
      u_ren  = (m_r > 0 && (m_b - u_pop + m_f) < OBUF) ? 1 : 0;
      if (m_f != 0 && q.size() > m_b) begin
        if (q[m_b].dbe) m_dbe_err = 1'b1;
        else if (q[m_b].sbe && m_sbe < 65535) m_sbe++;
      end
      if (u_pop != 0) void'(q.pop_front());
      if (u_push != 0) begin
        w.d = in_dat; w.sbe = inj_sbe(in_dat); w.dbe = inj_dbe(in_dat);
        q.push_back(w);
      end
      m_b = m_b - u_pop + m_f;
      m_f = u_ren;
      m_r = m_r + u_push - u_ren;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      e_rdy = (m_r != DEPTH);
      e_vld = (m_b > 0);
      e_pop = e_vld && out_rdy;
      e_ren = (m_r > 0) && ((m_b - int'(e_pop) + m_f) < OBUF);
      check("in_rdy", 64'(in_rdy), 64'(e_rdy));
      check("out_vld", 64'(out_vld), 64'(e_vld));
      if (e_vld) begin
        check("out_dat", 64'(out_dat), 64'(q[0].d));
        check("out_dbe", 64'(out_dbe), 64'(q[0].dbe));
      end
      check("occ", 64'(occ), 64'(q.size()));
      check("ram_ren", 64'(ram_ren), 64'(e_ren));
      check("ram_wen", 64'(ram_wen), 64'(in_vld && e_rdy));
      check("sbe_cnt", 64'(sbe_cnt), 64'(m_sbe));
      check("dbe_err", 64'(dbe_err), 64'(m_dbe_err));
    end
  end

  int            n, pops, cyc;
  logic [15:0]   dmask;
  bit            wrap_seen;
  logic [AW-1:0] prev_wadr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic note_pop;
    if (out_vld && out_rdy) begin
      pops++;
      if (out_dbe) dmask[out_dat[3:0]] = 1'b1;
    end
  endtask

  task automatic drain(input string name, input int limit);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < limit && q.size() != 0; i++) begin
      note_pop();
      tick();
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_dbe", 64'(out_dbe), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_sbe_cnt", 64'(sbe_cnt), 64'd0);
    check("rst_dbe_err", 64'(dbe_err), 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_ram_ren", 64'(ram_ren), 64'd0);
    check("rst_addrs", 64'({ram_wadr, ram_radr}), 64'd0);
    $display("reset state checked");

    // Single word latency
    in_vld = 1'b1; in_dat = 48'h0000_DEAD_BEEF; out_rdy = 1'b1;
    #1;
    check("t1_wen", 64'(ram_wen), 64'd1);
    check("t1_wadr", 64'(ram_wadr), 64'd0);
    check("t1_wdat", 64'(ram_wdat), 64'h0000_DEAD_BEEF);
    tick(); in_vld = 1'b0;
    check("t1_occ_after_push", 64'(occ), 64'd1);
    check("t1_vld_t1", 64'(out_vld), 64'd0);
    tick();
    check("t1_vld_t2", 64'(out_vld), 64'd0);
    tick();
    check("t1_vld_t3", 64'(out_vld), 64'd1);
    check("t1_dat_t3", 64'(out_dat), 64'h0000_DEAD_BEEF);
    tick();
    check("t1_occ_after_pop", 64'(occ), 64'd0);
    check("t1_vld_t4", 64'(out_vld), 64'd0);
    $display("single word: pushed DEADBEEF, popped at T+3");

    // Fill to full with pop side stalled
    out_rdy = 1'b0; n = 0;
    for (cyc = 0; cyc < 700 && in_rdy; cyc++) begin
      in_vld = 1'b1; in_dat = DB'(n); n++;
      tick();
    end
    check("full_accepted", 64'(n), 64'd514);
    check("full_occ", 64'(occ), 64'd514);
    check("full_in_rdy", 64'(in_rdy), 64'd0);
    in_dat = 48'd999;
    tick();
    in_vld = 1'b0;
    check("full_no_write_occ", 64'(occ), 64'd514);
    out_rdy = 1'b1;
    #1;
    check("full_pop_read", 64'(ram_ren), 64'd1);
    check("full_rdy_same_cycle", 64'(in_rdy), 64'd0);
    tick(); out_rdy = 1'b0;
    check("full_rdy_next_cycle", 64'(in_rdy), 64'd1);
    check("full_occ_after_pop", 64'(occ), 64'd513);
    drain("full_drain", 2000);
    $display("fill: %0d words accepted, drained", n);

    // Streaming push+pop
    in_vld = 1'b1; out_rdy = 1'b1; pops = 0; wrap_seen = 1'b0; prev_wadr = ram_wadr;
    for (int c = 0; c < 2000; c++) begin
      in_dat = DB'(c);
      if (c > 0 && prev_wadr == 9'd511 && ram_wadr == 9'd0) wrap_seen = 1'b1;
      prev_wadr = ram_wadr;
      if (out_vld) pops++;
      tick();
    end
    check("stream_pops", 64'(pops), 64'd1997);
    check("stream_wrap", 64'(wrap_seen), 64'd1);
    drain("stream_drain", 100);
    $display("stream: 2000 words, %0d popped inside window", pops);

    // Random backpressure
    n = 0; pops = 0; dmask = '0;
    for (cyc = 0; cyc < 40000 && n < 10000; cyc++) begin
      in_vld  = ($urandom_range(0, 9) < 7);
      in_dat  = {16'h0, $urandom()};
      out_rdy = ($urandom_range(0, 9) < 6);
      if (in_vld && in_rdy) n++;
      note_pop();
      tick();
    end
    drain("rand_drain", 2000);
    check("rand_accepted", 64'(n), 64'd10000);
    check("rand_popped", 64'(pops), 64'd10000);
    $display("random: %0d pushed, %0d popped", n, pops);

    // ECC flags
    dmask = '0; out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vld = 1'b1; in_dat = ECC_BASE + DB'(i);
      note_pop();
      tick();
    end
    drain("ecc_drain", 100);
    check("ecc_dbe_words", 64'(dmask), 64'h1200);
    check("ecc_sbe_cnt", 64'(sbe_cnt), 64'd1);
    check("ecc_dbe_err", 64'(dbe_err), 64'd1);
    $display("ecc: sbe_cnt=%0d dbe_err=%0d dbe_mask=%h", sbe_cnt, dbe_err, dmask);

    // Reset with words stored and a read in flight
    out_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_vld = 1'b1; in_dat = 48'h5000 + DB'(i);
      tick();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_rdy = 1'b1;
    #1;
    check("mrst_out_vld", 64'(out_vld), 64'd0);
    check("mrst_occ", 64'(occ), 64'd0);
    check("mrst_in_rdy", 64'(in_rdy), 64'd1);
    check("mrst_dbe_err", 64'(dbe_err), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_stale", 64'(out_vld), 64'd0);
    end
    $display("mid-run reset: storage discarded");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
